// File: rtl/capture_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | capture_sequencer_if: CPU / CCD_Capture / imgdetect bundle   Rev 1.0   |
// +------------------------------------------------------------------------+
interface capture_sequencer_if;
  logic        iREQ;
  logic        iABORT;
  logic        iACK;
  logic [31:0] iFrame_Cont;
  logic [3:0]  iLoc;
  logic        iInt;
  logic        oSTART;
  logic        oEND;
  logic        oBusy;
  logic        oDone;
  logic        oTimeout;
  logic [3:0]  oLoc;
  logic [2:0]  oState;

  modport slave (
    input  iREQ, iABORT, iACK, iFrame_Cont, iLoc, iInt,
    output oSTART, oEND, oBusy, oDone, oTimeout, oLoc, oState
  );

  modport master (
    output iREQ, iABORT, iACK, iFrame_Cont, iLoc, iInt,
    input  oSTART, oEND, oBusy, oDone, oTimeout, oLoc, oState
  );
endinterface
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | capture_sequencer: frame-stable board location scan controller Rev 1.0 |
// +------------------------------------------------------------------------+
module capture_sequencer #(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned MAX_FRAMES    = 60,
  parameter int unsigned LOC_MAX       = 8
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  capture_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SKIP  = 3'd2,
    S_WAIT  = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] C_NO_LOC  = 4'hF;
  localparam logic [3:0] C_STABLE  = 4'(STABLE_FRAMES);
  localparam logic [7:0] C_MAX     = 8'(MAX_FRAMES);
  localparam logic [3:0] C_LOC_MAX = 4'(LOC_MAX);

  state_t      state_q;
  logic [31:0] prev_frame_q;
  logic        frame_hit_q;
  logic [3:0]  frame_loc_q;
  logic [3:0]  cand_q;
  logic [3:0]  run_q;
  logic [7:0]  frames_q;
  logic        abort_q;
  logic [3:0]  result_q;
  logic        timeout_res_q;
  logic        start_q;
  logic        end_q;
  logic        busy_q;
  logic        done_q;
  logic        timeout_q;
  logic [3:0]  loc_q;

  logic        tick_d;
  logic        int_hit_d;
  logic        closing_hit_d;
  logic [3:0]  closing_loc_d;
  logic [3:0]  cand_d;
  logic [3:0]  run_d;
  logic [7:0]  frames_d;

  // A pulse arriving on the tick cycle belongs to the frame that is closing.
  always_comb begin
    tick_d        = (bus.iFrame_Cont != prev_frame_q);
    int_hit_d     = bus.iInt && (bus.iLoc <= C_LOC_MAX);
    closing_hit_d = int_hit_d || frame_hit_q;
    closing_loc_d = int_hit_d ? bus.iLoc : frame_loc_q;
    frames_d      = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;
    cand_d        = cand_q;
    run_d         = run_q;
    if (closing_hit_d && (closing_loc_d == cand_q) && (run_q != 4'd0)) begin
      run_d = run_q + 4'd1;
    end else if (closing_hit_d) begin
      cand_d = closing_loc_d;
      run_d  = 4'd1;
    end else begin
      run_d = 4'd0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q       <= S_IDLE;
      prev_frame_q  <= 32'd0;
      frame_hit_q   <= 1'b0;
      frame_loc_q   <= 4'd0;
      cand_q        <= 4'd0;
      run_q         <= 4'd0;
      frames_q      <= 8'd0;
      abort_q       <= 1'b0;
      result_q      <= C_NO_LOC;
      timeout_res_q <= 1'b0;
      start_q       <= 1'b0;
      end_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      loc_q         <= C_NO_LOC;
    end else begin
      prev_frame_q <= bus.iFrame_Cont;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.iREQ) begin
            state_q     <= S_START;
            busy_q      <= 1'b1;
            run_q       <= 4'd0;
            cand_q      <= 4'd0;
            frames_q    <= 8'd0;
            frame_hit_q <= 1'b0;
            abort_q     <= 1'b0;
          end
        end
        S_START: begin
          start_q <= 1'b1;
          if (bus.iABORT) begin
            abort_q <= 1'b1;
            state_q <= S_STOP;
          end else begin
            state_q <= S_SKIP;
          end
        end
        S_SKIP: begin
          if (bus.iABORT) begin
            abort_q <= 1'b1;
            state_q <= S_STOP;
          end else if (tick_d) begin
            frame_hit_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.iABORT) begin
            abort_q <= 1'b1;
            state_q <= S_STOP;
          end else if (tick_d) begin
            frames_q    <= frames_d;
            cand_q      <= cand_d;
            run_q       <= run_d;
            frame_hit_q <= 1'b0;
            if (run_d == C_STABLE) begin
              result_q      <= cand_d;
              timeout_res_q <= 1'b0;
              state_q       <= S_STOP;
            end else if (frames_d >= C_MAX) begin
              result_q      <= C_NO_LOC;
              timeout_res_q <= 1'b1;
              state_q       <= S_STOP;
            end
          end else if (int_hit_d) begin
            frame_hit_q <= 1'b1;
            frame_loc_q <= bus.iLoc;
          end
        end
        S_STOP: begin
          end_q  <= 1'b1;
          busy_q <= 1'b0;
          if (abort_q) begin
            state_q <= S_IDLE;
          end else begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            timeout_q <= timeout_res_q;
            loc_q     <= result_q;
          end
        end
        S_DONE: begin
          if (bus.iACK) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.oSTART   = start_q;
  assign bus.oEND     = end_q;
  assign bus.oBusy    = busy_q;
  assign bus.oDone    = done_q;
  assign bus.oTimeout = timeout_q;
  assign bus.oLoc     = loc_q;
  assign bus.oState   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_capture_sequencer: randomized scans against a frame-level model     |
// +------------------------------------------------------------------------+
module tb_capture_sequencer;
  localparam int STABLE = 3;
  localparam int MAXF   = 6;
  localparam int LOCMAX = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  capture_sequencer_if bus();

  capture_sequencer #(
    .STABLE_FRAMES(STABLE),
    .MAX_FRAMES   (MAXF),
    .LOC_MAX      (LOCMAX)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] seq [16];
  logic [3:0] last_loc = 4'hF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level outcome: walk the per-frame results as a stream of streaks.
  function automatic void predict(output int n, output logic [3:0] loc, output bit to);
    int streak = 0;
    logic [3:0] prev = 4'hF;
    n = MAXF; loc = 4'hF; to = 1'b1;
    for (int k = 0; k < MAXF && to; k++) begin
      if (int'(seq[k]) > LOCMAX) streak = 0;
      else if (streak > 0 && seq[k] == prev) streak++;
      else streak = 1;
      prev = seq[k];
      if (streak == STABLE) begin
        n = k + 1; loc = seq[k]; to = 1'b0;
      end
    end
  endfunction

  function automatic void set_seq6(input logic [23:0] v);
    for (int k = 0; k < 16; k++) seq[k] = (k < 6) ? v[23 - 4*k -: 4] : 4'hF;
  endfunction

  task automatic cyc();
    @(negedge clk);
    bus.iREQ = 1'b0; bus.iABORT = 1'b0; bus.iACK = 1'b0; bus.iInt = 1'b0;
  endtask

  // One frame: optional decoy pulses, the deciding pulse (possibly on the tick), then the tick.
  task automatic drive_frame(input logic [3:0] loc);
    int len   = int'($urandom_range(2, 5));
    int place = int'($urandom_range(0, len));
    bit bad   = int'(loc) > LOCMAX;
    for (int c = 0; c < len; c++) begin
      cyc();
      if (c == place) begin
        bus.iInt = 1'b1; bus.iLoc = loc;
      end else if (c < place && $urandom_range(0, 1) == 1) begin
        bus.iInt = 1'b1;
        bus.iLoc = bad ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 15));
      end
    end
    cyc();
    bus.iFrame_Cont = bus.iFrame_Cont + 32'd1;
    if (place == len) begin
      bus.iInt = 1'b1; bus.iLoc = loc;
    end
  endtask

  task automatic begin_scan();
    cyc(); chk("idle_state", bus.oState, 0);
    bus.iREQ = 1'b1;
    cyc(); chk("start_state", bus.oState, 1); chk("start_early", bus.oSTART, 0);
    cyc(); chk("start_pulse", bus.oSTART, 1); chk("skip_state", bus.oState, 2);
    chk("busy", bus.oBusy, 1);
    bus.iInt = 1'b1; bus.iLoc = 4'($urandom_range(0, 8));
    cyc(); chk("start_once", bus.oSTART, 0);
    bus.iFrame_Cont = bus.iFrame_Cont + 32'd1;
  endtask

  task automatic run_scan(input bit poke);
    int n; logic [3:0] eloc; bit eto;
    predict(n, eloc, eto);
    begin_scan();
    for (int k = 0; k < n; k++) begin
      drive_frame(seq[k]);
      if (poke && k == 0) begin
        cyc(); chk("poke_wait", bus.oState, 3);
        bus.iREQ = 1'b1; bus.iACK = 1'b1;
        cyc(); chk("poke_ignored", bus.oState, 3); chk("poke_done", bus.oDone, 0);
      end
    end
    cyc(); chk("stop_state", bus.oState, 4); chk("end_early", bus.oEND, 0);
    cyc(); chk("end_pulse", bus.oEND, 1); chk("done", bus.oDone, 1);
    chk("loc", bus.oLoc, eloc); chk("timeout", bus.oTimeout, eto);
    chk("done_state", bus.oState, 5); chk("done_busy", bus.oBusy, 0);
    cyc(); chk("end_once", bus.oEND, 0);
    last_loc = eloc;
  endtask

  task automatic ack(input int hold);
    bit stable = 1'b1;
    logic to_seen = bus.oTimeout;
    for (int i = 0; i < hold; i++) begin
      cyc();
      if (bus.oDone !== 1'b1 || bus.oLoc !== last_loc || bus.oState !== 3'd5 ||
          bus.oTimeout !== to_seen || bus.oEND !== 1'b0) stable = 1'b0;
    end
    chk("done_hold", stable, 1);
    bus.iACK = 1'b1;
    cyc(); chk("ack_idle", bus.oState, 0); chk("ack_done", bus.oDone, 0);
    chk("ack_timeout", bus.oTimeout, 0); chk("ack_loc", bus.oLoc, last_loc);
  endtask

  initial begin
    bus.iREQ = 1'b0; bus.iABORT = 1'b0; bus.iACK = 1'b0; bus.iInt = 1'b0;
    bus.iLoc = 4'd0; bus.iFrame_Cont = 32'hFFFF_FFFD;
    repeat (3) cyc();
    chk("rst_state", bus.oState, 0); chk("rst_start", bus.oSTART, 0);
    chk("rst_end", bus.oEND, 0); chk("rst_busy", bus.oBusy, 0);
    chk("rst_done", bus.oDone, 0); chk("rst_timeout", bus.oTimeout, 0);
    chk("rst_loc", bus.oLoc, 4'hF);
    rst_n = 1'b1;

    set_seq6(24'h555FFF); run_scan(1'b0); ack(3);     // crosses the 32-bit counter wrap
    set_seq6(24'h22777F); run_scan(1'b1); ack(100);
    set_seq6(24'hC9FC9F); run_scan(1'b0); ack(2);     // no valid hit at all
    set_seq6(24'hFFF555); run_scan(1'b0); ack(1);     // success on the last allowed frame
    set_seq6(24'h11F111); run_scan(1'b0); ack(2);

    // Abort on the very tick that would have completed a stable run.
    begin_scan();
    drive_frame(4'd3); drive_frame(4'd3); drive_frame(4'd3);
    bus.iABORT = 1'b1;
    cyc(); chk("abort_stop", bus.oState, 4); chk("abort_end_early", bus.oEND, 0);
    cyc(); chk("abort_end", bus.oEND, 1); chk("abort_idle", bus.oState, 0);
    chk("abort_done", bus.oDone, 0); chk("abort_loc", bus.oLoc, last_loc);
    begin
      bit quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
        cyc();
        if (bus.oEND !== 1'b0 || bus.oDone !== 1'b0 || bus.oState !== 3'd0) quiet = 1'b0;
      end
      chk("abort_quiet", quiet, 1);
    end

    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 3))
          0:       seq[k] = 4'd3;
          1:       seq[k] = 4'd6;
          2:       seq[k] = 4'd3;
          default: seq[k] = 4'($urandom_range(9, 15));
        endcase
      end
      run_scan(1'b0);
      ack(int'($urandom_range(1, 4)));
    end

    // Reset in the middle of a scan.
    begin_scan();
    drive_frame(4'd4); drive_frame(4'd4);
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    chk("mid_rst_state", bus.oState, 0); chk("mid_rst_busy", bus.oBusy, 0);
    chk("mid_rst_end", bus.oEND, 0); chk("mid_rst_done", bus.oDone, 0);
    chk("mid_rst_loc", bus.oLoc, 4'hF); chk("mid_rst_start", bus.oSTART, 0);
    begin
      bit quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin
        cyc();
        if (bus.oEND !== 1'b0 || bus.oState !== 3'd0) quiet = 1'b0;
      end
      chk("mid_rst_no_end", quiet, 1);
    end
    last_loc = 4'hF;
    set_seq6(24'h888FFF); run_scan(1'b0); ack(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
